ifu_fetch: RTL and testbench

//  Instruction fetch unit: owns the architectural PC register and fetches one instruction at a time from instruction memory.

---
 rtl/ifu_fetch_if.sv | 28 ++
 rtl/ifu_fetch.sv | 121 ++++++++++++
 tb/tb_ifu_fetch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus
// the fetched-instruction handshake toward decode.
interface ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the architectural PC, issues one fetch at a
// time, hands the word to decode and stops with a sticky fault on errors.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_next_pc,
    input  logic        i_pc_update,
    output logic [31:0] o_pc,
    output logic        o_fetch_fault,
    output logic [1:0]  o_fault_cause,
    output logic [31:0] o_fetch_count,
    ifu_fetch_if.master bus
);
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_EXEC,
        S_FAULT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_inst;
    logic [31:0]   r_inst_pc;
    logic [31:0]   r_count;
    logic [1:0]    r_cause;
    logic [CW-1:0] r_wait;

    logic w_accept;
    logic w_rsp_ok;
    logic w_rsp_err;
    logic w_timeout;
    logic w_handshake;
    logic w_load_pc;
    logic w_misalign;

    always_comb begin
        w_accept    = (r_state == S_REQ) && bus.imem_req_ready;
        w_rsp_ok    = (r_state == S_WAIT) && bus.imem_rsp_valid && !bus.imem_rsp_err;
        w_rsp_err   = (r_state == S_WAIT) && bus.imem_rsp_valid && bus.imem_rsp_err;
        // A response arriving on the last allowed cycle takes priority over the timeout.
        w_timeout   = (r_state == S_WAIT) && !bus.imem_rsp_valid && (r_wait == CW'(MAX_WAIT));
        w_handshake = (r_state == S_OUT) && bus.inst_ready;
        w_load_pc   = i_pc_update && (w_handshake || (r_state == S_EXEC));
        w_misalign  = (i_next_pc[1:0] != 2'b00);

        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_REQ;
            S_REQ:   if (w_accept) w_next = S_WAIT;
            S_WAIT: begin
                if (w_rsp_ok)                    w_next = S_OUT;
                else if (w_rsp_err || w_timeout) w_next = S_FAULT;
            end
            S_OUT: begin
                if (w_handshake) begin
                    if (w_load_pc) w_next = w_misalign ? S_FAULT : S_REQ;
                    else           w_next = S_EXEC;
                end
            end
            S_EXEC:  if (w_load_pc) w_next = w_misalign ? S_FAULT : S_REQ;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_count   <= '0;
            r_cause   <= '0;
            r_wait    <= '0;
        end else begin
            r_state <= w_next;

            if (w_accept)
                r_wait <= '0;
            else if ((r_state == S_WAIT) && !bus.imem_rsp_valid && !w_timeout)
                r_wait <= r_wait + CW'(1);

            if (w_rsp_ok) begin
                r_inst    <= bus.imem_rsp_data;
                r_inst_pc <= r_pc;
            end

            if (w_rsp_err)
                r_cause <= 2'b01;
            else if (w_timeout)
                r_cause <= 2'b10;
            else if (w_load_pc && w_misalign)
                r_cause <= 2'b11;

            if (w_handshake)
                r_count <= r_count + 32'd1;

            if (w_load_pc)
                r_pc <= i_next_pc;
        end
    end

    assign bus.imem_req_valid = (r_state == S_REQ);
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = (r_state == S_OUT);
    assign bus.inst           = r_inst;
    assign bus.inst_pc        = r_inst_pc;
    assign o_pc               = r_pc;
    assign o_fetch_fault      = (r_state == S_FAULT);
    assign o_fault_cause      = r_cause;
    assign o_fetch_count      = r_count;
endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch with a transaction-level
// model of the PC / fetch-count sequence.
module tb_ifu_fetch;
    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int unsigned MW  = 6;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_update;
    logic [31:0] pc;
    logic        fetch_fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_pass   = 0;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_next_pc     (next_pc),
        .i_pc_update   (pc_update),
        .o_pc          (pc),
        .o_fetch_fault (fetch_fault),
        .o_fault_cause (fault_cause),
        .o_fetch_count (fetch_count),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        pc_update = 1'b0;
        next_pc   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(output bit found, output int cycles, output logic [31:0] addr);
        found = 1'b0; cycles = 0; addr = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid === 1'b1) begin
                found = 1'b1; cycles = i; addr = bus.imem_req_addr;
                break;
            end
        end
    endtask

    task automatic serve(input int req_lat, input int rsp_lat, input logic [31:0] data, input bit err);
        repeat (req_lat) @(negedge clk);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        repeat (rsp_lat) @(negedge clk);
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = data; bus.imem_rsp_err = err;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_err = 1'b0;
    endtask

    task automatic retire(input int ack_lat, input int upd_lat, input logic [31:0] npc, input bit coinc);
        repeat (ack_lat) @(negedge clk);
        bus.inst_ready = 1'b1;
        if (coinc) begin pc_update = 1'b1; next_pc = npc; end
        @(negedge clk);
        bus.inst_ready = 1'b0; pc_update = 1'b0;
        if (!coinc) begin
            repeat (upd_lat) @(negedge clk);
            pc_update = 1'b1; next_pc = npc;
            @(negedge clk);
            pc_update = 1'b0;
        end
    endtask

    task automatic test_reset();
        bit f; int c; logic [31:0] a; logic [31:0] d;
        apply_reset();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.imem_req_valid, bus.inst_valid, fetch_fault, fault_cause, fetch_count, bus.inst, bus.inst_pc} !== '0)
            $display("FAIL reset_zero: got req=%b iv=%b flt=%b cause=%0d cnt=%h inst=%h ipc=%h want all 0",
                     bus.imem_req_valid, bus.inst_valid, fetch_fault, fault_cause, fetch_count, bus.inst, bus.inst_pc);
        else n_pass++;
        n_checks++;
        if (pc !== RPC) $display("FAIL reset_pc: got %h want %h", pc, RPC); else n_pass++;
        rst = 1'b0;
        wait_req(f, c, a);
        n_checks++;
        if (!(f && c == 0 && a === RPC))
            $display("FAIL first_req: got found=%0d cycle=%0d addr=%h want 1/0/%h", f, c, a, RPC);
        else n_pass++;
        d = $urandom;
        serve(0, 0, d, 1'b0);
        n_checks++;
        if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, d, RPC})
            $display("FAIL first_inst: got v=%b inst=%h pc=%h want 1/%h/%h", bus.inst_valid, bus.inst, bus.inst_pc, d, RPC);
        else n_pass++;
    endtask

    task automatic test_retire();
        bit f; int c; logic [31:0] a;
        for (int coinc = 0; coinc < 2; coinc++) begin
            if (coinc == 1) begin
                apply_reset();
                wait_req(f, c, a);
                serve(0, 0, $urandom, 1'b0);
            end
            retire(0, 1, 32'h8000_0004, coinc[0]);
            n_checks++;
            if ({fetch_count, pc} !== {32'd1, 32'h8000_0004})
                $display("FAIL retire_state_%0d: got cnt=%0d pc=%h want 1/80000004", coinc, fetch_count, pc);
            else n_pass++;
            wait_req(f, c, a);
            n_checks++;
            if (!(f && a === 32'h8000_0004))
                $display("FAIL retire_req_%0d: got found=%0d addr=%h want 1/80000004", coinc, f, a);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit f; int c; logic [31:0] a; logic [31:0] d;
        int dup;
        apply_reset();
        wait_req(f, c, a);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (!(bus.imem_req_valid === 1'b1 && bus.imem_req_addr === RPC))
                $display("FAIL req_hold_%0d: got v=%b addr=%h want 1/%h", i, bus.imem_req_valid, bus.imem_req_addr, RPC);
            else n_pass++;
            @(negedge clk);
        end
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        dup = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) dup++;
            @(negedge clk);
        end
        n_checks++;
        if (dup != 0) $display("FAIL no_dup_req: got %0d busy cycles with valid want 0", dup); else n_pass++;
        d = $urandom;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = d;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = ~d;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, d, RPC})
                $display("FAIL inst_hold_%0d: got v=%b inst=%h pc=%h want 1/%h/%h", i, bus.inst_valid, bus.inst, bus.inst_pc, d, RPC);
            else n_pass++;
            if (i < 3) @(negedge clk);
        end
        retire(0, 0, 32'h8000_0010, 1'b1);
        n_checks++;
        if ({fetch_count, bus.imem_req_valid, bus.imem_req_addr} !== {32'd1, 1'b1, 32'h8000_0010})
            $display("FAIL bp_retire: got cnt=%0d v=%b addr=%h want 1/1/80000010", fetch_count, bus.imem_req_valid, bus.imem_req_addr);
        else n_pass++;
    endtask

    task automatic test_errors();
        bit f; int c; logic [31:0] a; logic [31:0] d;
        apply_reset();
        wait_req(f, c, a);
        serve(0, 1, $urandom, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({fetch_fault, fault_cause, bus.imem_req_valid, bus.inst_valid} !== {1'b1, 2'b01, 1'b0, 1'b0})
                $display("FAIL bus_err_%0d: got flt=%b cause=%0d req=%b iv=%b want 1/1/0/0", i, fetch_fault, fault_cause, bus.imem_req_valid, bus.inst_valid);
            else n_pass++;
            @(negedge clk);
        end
        apply_reset();
        wait_req(f, c, a);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        repeat (MW) @(negedge clk);
        n_checks++;
        if (fetch_fault !== 1'b0) $display("FAIL timeout_early: got flt=%b want 0", fetch_fault); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({fetch_fault, fault_cause} !== {1'b1, 2'b10})
            $display("FAIL timeout: got flt=%b cause=%0d want 1/2", fetch_fault, fault_cause);
        else n_pass++;
        apply_reset();
        wait_req(f, c, a);
        d = $urandom;
        serve(0, MW, d, 1'b0);
        n_checks++;
        if ({fetch_fault, bus.inst_valid, bus.inst} !== {1'b0, 1'b1, d})
            $display("FAIL rsp_at_limit: got flt=%b iv=%b inst=%h want 0/1/%h", fetch_fault, bus.inst_valid, bus.inst, d);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        bit f; int c; logic [31:0] a;
        apply_reset();
        wait_req(f, c, a);
        serve(0, 0, $urandom, 1'b0);
        retire(1, 0, 32'h8000_0006, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({fetch_fault, fault_cause, pc, bus.imem_req_valid} !== {1'b1, 2'b11, 32'h8000_0006, 1'b0})
                $display("FAIL misalign_%0d: got flt=%b cause=%0d pc=%h req=%b want 1/3/80000006/0", i, fetch_fault, fault_cause, pc, bus.imem_req_valid);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midop();
        bit f; int c; logic [31:0] a; logic [31:0] d;
        apply_reset();
        wait_req(f, c, a);
        serve(0, 0, $urandom, 1'b0);
        retire(0, 0, 32'h8000_0100, 1'b1);
        wait_req(f, c, a);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({pc, fetch_count} !== {RPC, 32'd0})
            $display("FAIL async_rst: got pc=%h cnt=%0d want %h/0", pc, fetch_count, RPC);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, fetch_count} !== {1'b1, RPC, 1'b0, 32'd0})
                $display("FAIL stale_rsp_%0d: got req=%b addr=%h iv=%b cnt=%0d want 1/%h/0/0", i, bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, fetch_count, RPC);
            else n_pass++;
        end
        bus.imem_rsp_valid = 1'b0;
        d = $urandom;
        serve(0, 0, d, 1'b0);
        n_checks++;
        if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, d, RPC})
            $display("FAIL refetch: got v=%b inst=%h pc=%h want 1/%h/%h", bus.inst_valid, bus.inst, bus.inst_pc, d, RPC);
        else n_pass++;
    endtask

    task automatic test_random();
        bit f; int c; logic [31:0] a; logic [31:0] d; logic [31:0] npc;
        logic [31:0] model_pc;
        logic [31:0] model_count;
        apply_reset();
        model_pc = RPC;
        model_count = 0;
        for (int t = 0; t < 30; t++) begin
            wait_req(f, c, a);
            n_checks++;
            if (!(f && a === model_pc)) $display("FAIL rnd_req_%0d: got found=%0d addr=%h want 1/%h", t, f, a, model_pc);
            else n_pass++;
            d = $urandom;
            serve($urandom_range(0, 3), $urandom_range(0, MW), d, 1'b0);
            n_checks++;
            if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, d, model_pc})
                $display("FAIL rnd_inst_%0d: got v=%b inst=%h pc=%h want 1/%h/%h", t, bus.inst_valid, bus.inst, bus.inst_pc, d, model_pc);
            else n_pass++;
            npc = $urandom & 32'hFFFF_FFFC;
            retire($urandom_range(0, 3), $urandom_range(0, 3), npc, 1'($urandom_range(0, 1)));
            model_count = model_count + 1;
            model_pc = npc;
            n_checks++;
            if ({fetch_count, pc, fetch_fault} !== {model_count, model_pc, 1'b0})
                $display("FAIL rnd_retire_%0d: got cnt=%0d pc=%h flt=%b want %0d/%h/0", t, fetch_count, pc, fetch_fault, model_count, model_pc);
            else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_retire();
        test_backpressure();
        test_errors();
        test_misaligned();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
